piso_serializer32: RTL and testbench

//   Parallel-in serial-out stage directly downstream of the 32-bit PIPO register.

---
 rtl/piso_serializer32_if.sv | 49 ++++
 rtl/piso_serializer32.sv | 139 +++++++++++++
 tb/tb_piso_serializer32.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer32_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer32_if
//  Description : Load handshake and serial output bundle for piso_serializer32.
//                The master side is the surrounding logic: it presents words
//                and applies sink backpressure. The slave side is the
//                serializer.
//  Revision    : 1.0  initial release
// ============================================================================
interface piso_serializer32_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output din,
    output load_valid,
    output sout_ready,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  frame_end,
    input  busy
  );

  modport slave (
    input  din,
    input  load_valid,
    input  sout_ready,
    output load_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output frame_end,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/piso_serializer32.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer32
//  Description : Parallel-in serial-out stage. Takes a WIDTH-bit word through
//                a valid/ready handshake and shifts it out one bit per cycle
//                the sink is ready, flagging the first and last bit of each
//                word. All state changes on the falling clock edge so it sits
//                on the same edge as the upstream parallel register.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_serializer32 #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer32_if.slave  bus
);

  localparam int             CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0] w_shifted;
  logic             w_head;
  logic             w_shifting;
  logic             w_last;
  logic             w_load_ready;
  logic             w_accept;

  // Bit order only changes which end of the register is presented and which
  // way the word moves; zeros fill in behind the outgoing bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_head    = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_head    = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_last     = (r_cnt == CNT_ZERO);

  // A new word can enter when idle, or on the very edge the last bit of the
  // current word is consumed, which gives back-to-back words with no bubble.
  // Held low during reset so nothing is taken while the block is cleared.
  always_comb begin
    w_load_ready = 1'b0;
    if (!rst) begin
      w_load_ready = (r_state == ST_IDLE) ||
                     (w_shifting && w_last && bus.sout_ready);
    end
  end

  assign w_accept = bus.load_valid && w_load_ready;

  // State, shift register and bit counter update on the falling edge;
  // reset clears everything immediately, discarding any word in flight.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: load on accept, advance one bit per ready cycle, and
  // freeze completely while the sink stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = bus.din;
          w_cnt_nxt   = CNT_TOP;
        end
      end
      ST_SHIFT: begin
        if (bus.sout_ready) begin
          if (!w_last) begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else if (w_accept) begin
            w_shreg_nxt = bus.din;
            w_cnt_nxt   = CNT_TOP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Serial outputs are a pure decode of the registered state, so they stay
  // stable for the whole cycle and through stalls. The line idles at zero.
  always_comb begin
    bus.sout        = 1'b0;
    bus.sout_valid  = 1'b0;
    bus.busy        = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    if (w_shifting) begin
      bus.sout        = w_head;
      bus.sout_valid  = 1'b1;
      bus.busy        = 1'b1;
      bus.frame_start = (r_cnt == CNT_TOP);
      bus.frame_end   = w_last;
    end
  end

  assign bus.load_ready = w_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer32
//  Description : Directed bench for piso_serializer32. One instance sends
//                MSB first, a second sends LSB first. Outputs are sampled on
//                the rising edge, half a cycle away from the falling edge the
//                design updates on; inputs are changed 1 time unit later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso_serializer32;

  logic clk = 1'b0;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  piso_serializer32_if #(.WIDTH(32)) bus_m ();
  piso_serializer32_if #(.WIDTH(32)) bus_l ();

  piso_serializer32 #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_serializer32 #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the chosen instance; returns {valid, sout, fs, fe, busy, load_ready}.
  function automatic logic [5:0] snap(input bit lsb);
    if (lsb)
      return {bus_l.sout_valid, bus_l.sout, bus_l.frame_start,
              bus_l.frame_end, bus_l.busy, bus_l.load_ready};
    else
      return {bus_m.sout_valid, bus_m.sout, bus_m.frame_start,
              bus_m.frame_end, bus_m.busy, bus_m.load_ready};
  endfunction

  // Called with a word already presented and about to be accepted on the
  // coming falling edge; follows all 32 bits, then checks the return to idle.
  task automatic stream_word(input bit lsb, input logic [31:0] w, input string tag);
    logic [31:0] rx;
    logic [5:0]  s;
    logic        b;
    rx = '0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      s = snap(lsb);
      b = lsb ? w[k] : w[31-k];
      check_eq($sformatf("%s bit%0d", tag, k), {60'd0, s[5:2]},
               {60'd0, 1'b1, b, (k == 0), (k == 31)});
      rx = lsb ? {s[4], rx[31:1]} : {rx[30:0], s[4]};
      if (k == 0) begin
        #1;
        bus_m.load_valid = 1'b0;
        bus_l.load_valid = 1'b0;
      end
    end
    check_eq({tag, " word"}, {32'd0, rx}, {32'd0, w});
    @(posedge clk);
    check_eq({tag, " idle"}, {58'd0, snap(lsb)}, {58'd0, 6'b000001});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [63:0] stream;
    logic [5:0]  s;
    int          idx;
    int          stalls;
    int          nvalid;

    // ---- 1: reset with random inputs and the clock running ----------------
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_m.din        = $urandom;
      bus_m.load_valid = 1'($urandom_range(0, 1));
      bus_m.sout_ready = 1'($urandom_range(0, 1));
      bus_l.din        = $urandom;
      bus_l.load_valid = 1'($urandom_range(0, 1));
      bus_l.sout_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      check_eq($sformatf("rst msb %0d", i), {58'd0, snap(1'b0)}, 64'd0);
      check_eq($sformatf("rst lsb %0d", i), {58'd0, snap(1'b1)}, 64'd0);
      #1;
    end
    rst = 1'b0;
    bus_m.load_valid = 1'b0;
    bus_m.sout_ready = 1'b1;
    bus_m.din        = '0;
    bus_l.load_valid = 1'b0;
    bus_l.sout_ready = 1'b1;
    bus_l.din        = '0;
    #1;
    check_eq("rst release ready", {62'd0, bus_m.load_ready, bus_l.load_ready}, 64'd3);

    // ---- 2: single word, MSB first ----------------------------------------
    @(posedge clk);
    #1;
    bus_m.din        = 32'hA5A5_0F0F;
    bus_m.load_valid = 1'b1;
    stream_word(1'b0, 32'hA5A5_0F0F, "single");

    // ---- 3: back-to-back words with load_valid held -----------------------
    #1;
    stream = {32'hFFFF_0000, 32'h0000_FFFF};
    bus_m.din        = 32'hFFFF_0000;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      s = snap(1'b0);
      check_eq($sformatf("b2b bit%0d", k), {58'd0, s[5:2], s[0]},
               {59'd0, 1'b1, stream[63-k], (k % 32 == 0), (k % 32 == 31), (k % 32 == 31)});
      #1;
      if (k == 0) bus_m.din = 32'h0000_FFFF;
      if (k == 32) begin
        bus_m.load_valid = 1'b0;
        bus_m.din        = '0;
      end
    end
    @(posedge clk);
    check_eq("b2b idle", {63'd0, bus_m.sout_valid}, 64'd0);

    // ---- 4: five-cycle stall on bit 10 ------------------------------------
    #1;
    w = 32'h1234_5678;
    bus_m.din        = w;
    bus_m.load_valid = 1'b1;
    idx    = 0;
    stalls = 0;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      s = snap(1'b0);
      if (s[5]) nvalid++;
      if (idx < 32)
        check_eq($sformatf("stall c%0d", c), {60'd0, s[5:2]},
                 {60'd0, 1'b1, w[31-idx], (idx == 0), (idx == 31)});
      else
        check_eq($sformatf("stall idle c%0d", c), {62'd0, s[5:4]}, 64'd0);
      #1;
      if (c == 0) bus_m.load_valid = 1'b0;
      if (idx == 10 && stalls < 5) begin
        bus_m.sout_ready = 1'b0;
        stalls++;
      end else begin
        bus_m.sout_ready = 1'b1;
        if (idx < 32) idx++;
      end
    end
    check_eq("stall valid cycles", 64'(nvalid), 64'd37);

    // ---- 5: asynchronous reset in the middle of a word --------------------
    bus_m.din        = 32'hFFFF_FFFF;
    bus_m.load_valid = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      if (k == 0) begin
        #1;
        bus_m.load_valid = 1'b0;
      end
    end
    check_eq("midrst bit12", {62'd0, bus_m.sout_valid, bus_m.sout}, 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst async drop", {58'd0, snap(1'b0)}, 64'd0);
    #1;
    rst = 1'b0;
    bus_m.din        = 32'h0000_0001;
    bus_m.load_valid = 1'b1;
    #1;
    check_eq("midrst ready", {63'd0, bus_m.load_ready}, 64'd1);
    stream_word(1'b0, 32'h0000_0001, "after_rst");

    // ---- 6: LSB-first instance --------------------------------------------
    #1;
    bus_l.din        = 32'h0000_0003;
    bus_l.load_valid = 1'b1;
    stream_word(1'b1, 32'h0000_0003, "lsb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
